// File: rtl/lvds_tx_pkg.sv
// -----------------------------------------------------------------------------
// lvds_tx_pkg
// Shared definitions for the LVDS DDR link: serializer state encoding, default
// word geometry and the idle/training word. The receive-side deserializer and
// aligner import the same package so both ends agree on the idle pattern.
// No ports (package).
// -----------------------------------------------------------------------------
package lvds_tx_pkg;

  // Link states: pad undriven, training preamble, live data.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } lvds_tx_state_e;

  localparam int unsigned LVDS_WORD_W       = 10;
  localparam logic [9:0]  LVDS_IDLE_PATTERN = 10'h0F8;
  localparam int unsigned LVDS_TRAIN_WORDS  = 16;

  // Two bits leave per clock (one per edge), so a word spans WORD_W/2 cycles.
  function automatic int unsigned lvds_beats_per_word(input int unsigned word_w);
    return word_w / 2;
  endfunction

endpackage

// File: rtl/lvds_ddr_tx_serializer.sv
// -----------------------------------------------------------------------------
// lvds_ddr_tx_serializer
// Turns a valid/ready stream of parallel words into 2-bit-per-clock DDR beats
// for the D_OUT_0/D_OUT_1/OUTPUT_ENABLE pins of an IO_DS (SB_LVDS_OUTPUT) pad.
// After every enable a preamble of TRAIN_WORDS idle words is sent; in RUN an
// idle word is substituted whenever no data word is offered at a boundary.
// Runs in the pad's OUTPUT_CLK domain.
//
// Ports
//   clk            in   DDR output clock (same net as pad OUTPUT_CLK)
//   resetn         in   synchronous active-low reset
//   tx_enable      in   level request to run the link
//   s_data         in   word to send, bit 0 first
//   s_valid        in   s_data valid
//   s_ready        out  word accepted on an edge with s_valid && s_ready
//   d_out_0        out  rising-edge bit (even bit index)
//   d_out_1        out  falling-edge bit (odd bit index)
//   output_enable  out  pad driver enable, 1 = drive
//   underrun       out  1-cycle pulse when an idle word replaces data in RUN
// -----------------------------------------------------------------------------
module lvds_ddr_tx_serializer
  import lvds_tx_pkg::*;
#(
  parameter int unsigned       WORD_W       = LVDS_WORD_W,
  parameter logic [WORD_W-1:0] IDLE_PATTERN = WORD_W'(LVDS_IDLE_PATTERN),
  parameter int unsigned       TRAIN_WORDS  = LVDS_TRAIN_WORDS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tx_enable,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              d_out_0,
  output logic              d_out_1,
  output logic              output_enable,
  output logic              underrun
);

  localparam int unsigned BEATS = lvds_beats_per_word(WORD_W);
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned CNT_W  = $clog2(TRAIN_WORDS + 1);
  localparam logic [BEAT_W-1:0] LAST    = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  TW_LAST = CNT_W'(TRAIN_WORDS - 1);

  lvds_tx_state_e    r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_train_cnt;
  logic [WORD_W-1:0] r_shreg;
  logic              r_d0;
  logic              r_d1;
  logic              r_oe;
  logic              r_underrun;

  logic              w_boundary;
  logic              w_last_train;
  logic              w_data_slot;
  logic              w_load;
  logic              w_idle_sub;
  logic [WORD_W-1:0] w_word;

  // A data slot is a word boundary where the next word may carry payload:
  // any RUN boundary, or the boundary that closes the final training word.
  always_comb begin
    w_boundary   = (r_beat == LAST);
    w_last_train = (r_train_cnt == TW_LAST);
    w_data_slot  = w_boundary &&
                   ((r_state == ST_RUN) || ((r_state == ST_TRAIN) && w_last_train));
    w_load       = 1'b0;
    w_idle_sub   = 1'b0;
    w_word       = IDLE_PATTERN;
    case (r_state)
      ST_OFF: w_load = tx_enable;
      ST_TRAIN, ST_RUN: begin
        // A low tx_enable at a boundary shuts the link instead of loading.
        if (w_boundary && tx_enable) begin
          w_load = 1'b1;
          if (w_data_slot) begin
            if (s_valid) begin
              w_word = s_data;
            end else begin
              w_idle_sub = 1'b1;
            end
          end
        end
      end
      default: w_load = 1'b0;
    endcase
  end

  assign s_ready = tx_enable && w_data_slot;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_OFF;
      r_beat      <= LAST;
      r_train_cnt <= '0;
      r_d0        <= 1'b0;
      r_d1        <= 1'b0;
      r_oe        <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_idle_sub;

      // Shifter: a load sends bits [1:0] straight out and parks the rest.
      if (w_load) begin
        r_d0    <= w_word[0];
        r_d1    <= w_word[1];
        r_shreg <= w_word >> 2;
        r_beat  <= '0;
      end else if ((r_state != ST_OFF) && !w_boundary) begin
        r_d0    <= r_shreg[0];
        r_d1    <= r_shreg[1];
        r_shreg <= r_shreg >> 2;
        r_beat  <= r_beat + BEAT_W'(1);
      end else begin
        // Idle in OFF, or the disable boundary: park the pad low.
        r_d0   <= 1'b0;
        r_d1   <= 1'b0;
        r_beat <= LAST;
      end

      case (r_state)
        ST_OFF: begin
          r_oe <= 1'b0;
          if (tx_enable) begin
            r_state     <= ST_TRAIN;
            r_train_cnt <= '0;
            r_oe        <= 1'b1;
          end
        end
        ST_TRAIN: begin
          if (w_boundary) begin
            if (!tx_enable) begin
              r_state <= ST_OFF;
              r_oe    <= 1'b0;
            end else if (w_last_train) begin
              r_state <= ST_RUN;
            end else begin
              r_train_cnt <= r_train_cnt + CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (w_boundary && !tx_enable) begin
            r_state <= ST_OFF;
            r_oe    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign d_out_0       = r_d0;
  assign d_out_1       = r_d1;
  assign output_enable = r_oe;
  assign underrun      = r_underrun;

endmodule
